aes_chain_ctrl: RTL

Block-cipher mode controller placed between the Avalon-side data path and the AES round core (`AES_endec_block` class).
- Applies ECB, CBC, CFB and optional CTR chaining, which the current AES wrapper latches but never applies.
- Owns the IV/counter register and a parametrised input FIFO.
- Drives the core through a start/done handshake with one block in flight.
- Provides output backpressure.

---
 rtl/aes_chain_ctrl_if.sv | 33 +++
 rtl/aes_chain_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/aes_chain_ctrl_if.sv
// aes_chain_ctrl_if: parameter, input-stream, AES-core and output-stream signals of aes_chain_ctrl
// slave  = controller view (aes_chain_ctrl), master = environment view (Avalon side + core)
//   param : iParam_load, iEndec, iMode[1:0], iIV[127:0] -> oParam_err, oBusy
//   input : iData_valid, iData[127:0] -> oData_ready
//   core  : oCore_valid, oCore_endec, oCore_data[127:0] <- iCore_valid, iCore_data[127:0]
//   output: oData_valid, oData[127:0] <- iData_ready
interface aes_chain_ctrl_if;
  logic         iParam_load;
  logic         iEndec;
  logic [1:0]   iMode;
  logic [127:0] iIV;
  logic         oParam_err;
  logic         oBusy;
  logic         iData_valid;
  logic         oData_ready;
  logic [127:0] iData;
  logic         oCore_valid;
  logic         oCore_endec;
  logic [127:0] oCore_data;
  logic         iCore_valid;
  logic [127:0] iCore_data;
  logic         oData_valid;
  logic         iData_ready;
  logic [127:0] oData;
  modport slave (
    input  iParam_load, iEndec, iMode, iIV, iData_valid, iData, iCore_valid, iCore_data, iData_ready,
    output oParam_err, oBusy, oData_ready, oCore_valid, oCore_endec, oCore_data, oData_valid, oData
  );
  modport master (
    output iParam_load, iEndec, iMode, iIV, iData_valid, iData, iCore_valid, iCore_data, iData_ready,
    input  oParam_err, oBusy, oData_ready, oCore_valid, oCore_endec, oCore_data, oData_valid, oData
  );
endinterface

// File: rtl/aes_chain_ctrl.sv
// aes_chain_ctrl: ECB/CBC/CFB(/CTR) chaining controller between the data path and the AES round core
// Ports: iClk, iRst_n (async, active-low), bus (aes_chain_ctrl_if.slave: param load, input FIFO
//   stream, one-block-in-flight core start/done handshake, output stream with backpressure).
// Parameters: FIFO_DEPTH (power of 2, >= 2), CTR_W (1..128, counter field in the low IV bits).
// Optional feature: define AES_CHAIN_CTR_EN to build CTR mode (iMode 11); otherwise mode 11 is rejected.
module aes_chain_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CTR_W      = 32
) (
  input logic             iClk,
  input logic             iRst_n,
  aes_chain_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CORE, OUT} stateT;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CTR_W < 1 || CTR_W > 128) begin : gBadParam
    $error("aes_chain_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and CTR_W must be 1..128");
  end

  stateT        state, stateNext;
  logic [127:0] fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]  count, countNext;
  logic         full, empty, push, pop;
  logic [1:0]   mode;
  logic         endec, paramErr, modeOk, loadOk, coreDone;
  logic [127:0] chain, hold, coreData, outData;
  logic [127:0] head, coreIn, result, chainNext, chainCtr;

  assign empty     = count == '0;
  assign push      = bus.iData_valid & ~full;
  assign head      = fifoMem[rdPtr];
  assign countNext = count + (AW + 1)'(push) - (AW + 1)'(pop);

`ifdef AES_CHAIN_CTR_EN
  // Only the low CTR_W bits count; the carry out of the field is discarded by the mask.
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);
  assign modeOk   = 1'b1;
  assign chainCtr = (chain & ~CTR_MASK) | ((chain + 128'd1) & CTR_MASK);
`else
  assign modeOk   = bus.iMode != 2'b11;
  assign chainCtr = chain;
`endif

  assign loadOk   = bus.iParam_load & (state == IDLE) & empty & modeOk;
  assign coreDone = (state == WAIT_CORE) & bus.iCore_valid;

  // CBC encrypt whitens the plaintext; CFB/CTR feed the chain register to the core.
  assign coreIn = mode == 2'b01 && !endec ? head ^ chain : mode[1] ? chain : head;
  assign result = mode == 2'b00 || (mode == 2'b01 && !endec) ? bus.iCore_data
                : mode == 2'b01 ? bus.iCore_data ^ chain : bus.iCore_data ^ hold;
  // Decrypt directions (CBC/CFB) chain on the ciphertext input, which is the held block.
  assign chainNext = mode == 2'b00 ? chain : mode == 2'b11 ? chainCtr
                   : endec ? hold : mode == 2'b01 ? bus.iCore_data : result;

  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) state <= IDLE;
    else state <= stateNext;

  always_comb begin
    stateNext = state;
    pop = 1'b0;
    case (state)
      IDLE:      if (!empty) begin
        pop = 1'b1;
        stateNext = ISSUE;
      end
      ISSUE:     stateNext = WAIT_CORE;
      WAIT_CORE: if (bus.iCore_valid) stateNext = OUT;
      default:   if (bus.iData_ready) stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      mode     <= 2'b00;
      endec    <= 1'b0;
      chain    <= '0;
      hold     <= '0;
      coreData <= '0;
      outData  <= '0;
      paramErr <= 1'b0;
    end else begin
      wrPtr    <= wrPtr + AW'(push);
      rdPtr    <= rdPtr + AW'(pop);
      count    <= countNext;
      full     <= countNext == FULL_CNT;
      paramErr <= bus.iParam_load & ~loadOk;
      if (loadOk) begin
        mode  <= bus.iMode;
        endec <= bus.iEndec;
        chain <= bus.iIV;
      end
      if (pop) begin
        hold     <= head;
        coreData <= coreIn;
      end
      if (coreDone) begin
        outData <= result;
        chain   <= chainNext;
      end
    end

  always_ff @(posedge iClk)
    if (push) fifoMem[wrPtr] <= bus.iData;

  assign bus.oParam_err  = paramErr;
  assign bus.oBusy       = !empty || state != IDLE;
  assign bus.oData_ready = ~full;
  assign bus.oCore_valid = state == ISSUE;
  assign bus.oCore_endec = endec & ~mode[1];
  assign bus.oCore_data  = coreData;
  assign bus.oData_valid = state == OUT;
  assign bus.oData       = outData;
endmodule
